button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 144 ++++++++++++++
 tb/tb_button_conditioner.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Pushbutton synchronizer, debouncer and press/release/long-press pulse generator.
// Optional long-press hold counter: define BUTTON_CONDITIONER_LONGPRESS_EN.
module button_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned LONG_CYCLES     = 50000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse
);

   localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      RELEASE_WAIT
   } state_e;

   logic          s1_q;
   logic          sync_q;
   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic          release_q, release_d;

   // Button is active low; the synchronizer carries the pressed sense.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q   <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         s1_q   <= ~btn;
         sync_q <= s1_q;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (sync_q) begin
               state_d = PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!sync_q) begin
               state_d = IDLE;
            end else if (cnt_q == CNT_MAX) begin
               state_d = HELD;
               level_d = 1'b1;
               press_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         HELD: begin
            if (!sync_q) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (sync_q) begin
               state_d = HELD;
            end else if (cnt_q == CNT_MAX) begin
               state_d   = IDLE;
               level_d   = 1'b0;
               release_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign level         = level_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;

`ifdef BUTTON_CONDITIONER_LONGPRESS_EN
   localparam logic [31:0] HOLD_END = 32'(LONG_CYCLES);
   localparam logic [31:0] HOLD_HIT = 32'(LONG_CYCLES - 1);

   logic [31:0] hold_q, hold_d;
   logic        long_q, long_d;

   // Saturating one past the hit value makes the pulse fire once per press.
   always_comb begin
      hold_d = hold_q;
      long_d = 1'b0;
      if (state_q == PRESS_WAIT && state_d == HELD) begin
         hold_d = '0;
      end else if (state_q == HELD && hold_q != HOLD_END) begin
         hold_d = hold_q + 32'd1;
         long_d = (hold_q == HOLD_HIT);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q <= '0;
         long_q <= 1'b0;
      end else begin
         hold_q <= hold_d;
         long_q <= long_d;
      end
   end

   assign long_pulse = long_q;
`else
   assign long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner (DEBOUNCE_CYCLES=4, LONG_CYCLES=20).
// Reference model: a level flips after DEBOUNCE_CYCLES+1 consecutive disagreeing samples.
module tb_button_conditioner;

   localparam int DEB  = 4;
   localparam int LONG = 20;
`ifdef BUTTON_CONDITIONER_LONGPRESS_EN
   localparam bit LP_EN = 1'b1;
`else
   localparam bit LP_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic btn = 1'b1;
   logic level, press_pulse, release_pulse, long_pulse;

   int n_tests = 0;
   int n_fail  = 0;

   button_conditioner #(
      .DEBOUNCE_CYCLES(DEB),
      .LONG_CYCLES    (LONG)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .btn          (btn),
      .level        (level),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse),
      .long_pulse   (long_pulse)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural reference model
   bit h0, h1, ms, m_held, armed;
   int run, hcnt;
   bit m_level, m_press, m_rel, m_long;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h0 = 0; h1 = 0; run = 0; hcnt = 0; armed = 0;
         m_level = 0; m_press = 0; m_rel = 0; m_long = 0;
      end else begin
         ms = h1;
         m_held = m_level && (run == 0);
         m_press = 0; m_rel = 0; m_long = 0;
         if (m_held && armed) begin
            hcnt++;
            if (hcnt == LONG) begin
               armed  = 0;
               m_long = LP_EN;
            end
         end
         run = (ms != m_level) ? run + 1 : 0;
         if (run == DEB + 1) begin
            m_level = !m_level;
            run = 0;
            if (m_level) begin
               m_press = 1; hcnt = 0; armed = 1;
            end else begin
               m_rel = 1; armed = 0;
            end
         end
         h1 = h0;
         h0 = ~btn;
      end
   end

   always @(negedge clk) begin
      chk("model", int'({level, press_pulse, release_pulse, long_pulse}),
          int'({m_level, m_press, m_rel, m_long}));
      chk("onehot", int'($countones({press_pulse, release_pulse, long_pulse}) <= 1), 1);
   end

   // Drive btn for the next edge, return at the following negedge.
   task automatic cyc(input logic b);
      btn = b;
      @(posedge clk);
      @(negedge clk);
   endtask

   typedef struct {
      logic       b;
      logic [3:0] exp;
   } vec_t;

   vec_t tbl[24];
   int pi, li, ri, np, nl, nr, lv_chg;
   logic lv0;

   initial begin
      for (int i = 0; i < 24; i++) begin
         int e;
         e = i + 1;
         tbl[i].b   = (i < 12) ? 1'b0 : 1'b1;
         tbl[i].exp = {(e >= 7 && e < 19), (e == 7), (e == 19), 1'b0};
      end

      #1;
      chk("reset_outputs", int'({level, press_pulse, release_pulse, long_pulse}), 0);
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      repeat (4) cyc(1'b1);

      // Clean press then clean release
      for (int i = 0; i < 24; i++) begin
         cyc(tbl[i].b);
         chk($sformatf("vec%0d", i),
             int'({level, press_pulse, release_pulse, long_pulse}), int'(tbl[i].exp));
      end
      repeat (4) cyc(1'b1);

      // Glitch: 3 cycles low
      np = 0; nr = 0;
      for (int j = 0; j < 14; j++) begin
         cyc((j < 3) ? 1'b0 : 1'b1);
         np += int'(press_pulse) + int'(release_pulse) + int'(long_pulse);
         nr += int'(level);
      end
      chk("glitch_pulses", np, 0);
      chk("glitch_level", nr, 0);

      // Release bounce from HELD
      repeat (10) cyc(1'b0);
      chk("bounce_pre_level", int'(level), 1);
      ri = -1; nr = 0;
      for (int j = 0; j < 16; j++) begin
         cyc((j == 2) ? 1'b0 : 1'b1);
         if (release_pulse) begin
            nr++;
            if (ri < 0) ri = j;
         end
      end
      chk("bounce_rel_idx", ri, 9);
      chk("bounce_rel_cnt", nr, 1);
      chk("bounce_level", int'(level), 0);
      repeat (3) cyc(1'b1);

      // Long press
      pi = -1; li = -1; np = 0; nl = 0;
      for (int j = 0; j < 40; j++) begin
         cyc(1'b0);
         if (press_pulse) begin np++; if (pi < 0) pi = j; end
         if (long_pulse)  begin nl++; if (li < 0) li = j; end
      end
      chk("long_press_idx", pi, 6);
      chk("long_press_cnt", np, 1);
      chk("long_cnt", nl, LP_EN ? 1 : 0);
      chk("long_idx", li, LP_EN ? 26 : -1);
      repeat (12) cyc(1'b1);

      // Reset in PRESS_WAIT with counter at 2
      repeat (5) cyc(1'b0);
      #1 rst_n = 1'b0;
      #1 chk("rst_pw_outputs", int'({level, press_pulse, release_pulse, long_pulse}), 0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      pi = -1; np = 0;
      for (int j = 0; j < 12; j++) begin
         cyc(1'b0);
         if (press_pulse) begin np++; if (pi < 0) pi = j; end
      end
      chk("rst_pw_press_idx", pi, 6);
      chk("rst_pw_press_cnt", np, 1);

      // Reset mid-hold discards the press
      #1 rst_n = 1'b0;
      #1 chk("rst_held_outputs", int'({level, press_pulse, release_pulse, long_pulse}), 0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      np = 0;
      for (int j = 0; j < 12; j++) begin
         cyc(1'b1);
         np += int'(press_pulse) + int'(release_pulse) + int'(long_pulse) + int'(level);
      end
      chk("rst_held_after", np, 0);

      // Chatter from IDLE and from HELD
      for (int k = 0; k < 2; k++) begin
         repeat (10) cyc(k == 0 ? 1'b1 : 1'b0);
         lv0 = level;
         np = 0; lv_chg = 0;
         for (int j = 0; j < 100; j++) begin
            cyc(j[0]);
            np += int'(press_pulse) + int'(release_pulse);
            lv_chg += int'(level != lv0);
         end
         chk($sformatf("chatter%0d_pulses", k), np, 0);
         chk($sformatf("chatter%0d_level", k), lv_chg, 0);
      end
      repeat (12) cyc(1'b1);

      // Random runs checked by the model
      for (int r = 0; r < 250; r++) begin
         int len;
         logic b;
         b   = 1'($urandom_range(0, 1));
         len = ($urandom_range(0, 7) == 0) ? $urandom_range(22, 30)
                                           : $urandom_range(1, 12);
         repeat (len) cyc(b);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
